// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline constants, the in-flight stage record and small helpers
// used by the hazard controller and its stage registers.
package hazard_ctrl_pkg;

   localparam int REG_W  = 5;
   localparam int TUSE_W = 2;
   localparam int TNEW_W = 2;

   localparam logic [TUSE_W-1:0] TUSE_NONE = 2'd3;
   localparam logic [TNEW_W-1:0] TNEW_MAX  = 2'd2;

   // D-stage selects use GRF/M/E; E-stage selects use pipe/M/W, so E and W share code 2.
   localparam logic [1:0] FWD_GRF = 2'd0;
   localparam logic [1:0] FWD_M   = 2'd1;
   localparam logic [1:0] FWD_E   = 2'd2;
   localparam logic [1:0] FWD_W   = 2'd2;

   typedef struct packed {
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  writeReg;
      logic              regWrite;
      logic [TNEW_W-1:0] tnew;
   } stage_rec_t;

   // A stage produces a value for src only if it writes a real register ($0 never matches).
   function automatic logic recMatch(stage_rec_t rec, logic [REG_W-1:0] src);
      return rec.regWrite && (rec.writeReg != '0) && (rec.writeReg == src);
   endfunction

   // Tnew counts down one per stage and bottoms out at zero.
   function automatic logic [TNEW_W-1:0] satDec(logic [TNEW_W-1:0] t);
      return (t == '0) ? '0 : t - 1'b1;
   endfunction

   // A D-stage read must wait when the producer's result is later than the consumer's need.
   function automatic logic tuseWait(stage_rec_t rec, logic [REG_W-1:0] src,
                                     logic [TUSE_W-1:0] tuse);
      return (tuse != TUSE_NONE) && recMatch(rec, src) && (tuse < rec.tnew);
   endfunction

endpackage

// File: rtl/hazard_stage_rec.sv
// One pipeline stage record {rs, rt, writeReg, regWrite, tnew} with an
// asynchronous clear, a bubble input and an optional Tnew countdown.
module hazard_stage_rec
   import hazard_ctrl_pkg::*;
#(
   parameter bit DEC_TNEW = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       bubble_i,
   input  stage_rec_t rec_i,
   output stage_rec_t rec_o
);

   stage_rec_t rec_q;
   stage_rec_t rec_d;

   // Next record: the incoming one with Tnew aged by a cycle, or an all-zero bubble.
   always_comb begin
      rec_d = rec_i;
      if (DEC_TNEW) begin
         rec_d.tnew = satDec(rec_i.tnew);
      end
      if (bubble_i) begin
         rec_d = '0;
      end
   end

   // Hold the record; reset empties the stage so nothing can match afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rec_q <= '0;
      end else begin
         rec_q <= rec_d;
      end
   end

   assign rec_o = rec_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Producer-side hazard control for the 5-stage MIPS pipeline: tracks the
// destination and Tnew of instructions in E/M/W, decides the D-stage stall,
// drives the D/E/M forwarding selects and counts stall cycles.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       D_rs,
   input  logic [4:0]       D_rt,
   input  logic [1:0]       D_rsTuse,
   input  logic [1:0]       D_rtTuse,
   input  logic [4:0]       D_writeReg,
   input  logic             D_regWrite,
   input  logic [1:0]       D_tnew,
   output logic             stall,
   output logic [1:0]       D_rsSel,
   output logic [1:0]       D_rtSel,
   output logic [1:0]       E_rsSel,
   output logic [1:0]       E_rtSel,
   output logic             M_rtSel,
   output logic [CNT_W-1:0] stall_cnt
);

   stage_rec_t dRec;
   stage_rec_t eRec;
   stage_rec_t mRec;
   stage_rec_t wRec;
   stage_rec_t wIn;
   logic [CNT_W-1:0] stallCnt_q;
   logic [CNT_W-1:0] stallCnt_d;
   logic unusedFields;

   // D-stage selects: E result first (youngest), then M result, else the GRF.
   function automatic logic [1:0] dFwdSel(stage_rec_t e, stage_rec_t m, logic [REG_W-1:0] src);
      if (recMatch(e, src) && (e.tnew == '0)) begin
         return FWD_E;
      end else if (recMatch(m, src) && (m.tnew == '0)) begin
         return FWD_M;
      end
      return FWD_GRF;
   endfunction

   // E-stage selects: M ALU result first, then W write data, else the pipeline register.
   function automatic logic [1:0] eFwdSel(stage_rec_t m, stage_rec_t w, logic [REG_W-1:0] src);
      if (recMatch(m, src) && (m.tnew == '0)) begin
         return FWD_M;
      end else if (recMatch(w, src)) begin
         return FWD_W;
      end
      return FWD_GRF;
   endfunction

   // Pack the D-stage instruction into a record; an illegal Tnew of 3 is treated as a load (2).
   always_comb begin
      dRec.rs       = D_rs;
      dRec.rt       = D_rt;
      dRec.writeReg = D_writeReg;
      dRec.regWrite = D_regWrite;
      dRec.tnew     = (D_tnew == 2'd3) ? TNEW_MAX : D_tnew;
   end

   // Anything that reaches W has its result ready, so W always enters with Tnew = 0.
   always_comb begin
      wIn      = mRec;
      wIn.tnew = '0;
   end

   hazard_stage_rec #(.DEC_TNEW(1'b0)) uStageE (
      .clk      (clk),
      .rst_n    (rst_n),
      .bubble_i (stall),
      .rec_i    (dRec),
      .rec_o    (eRec)
   );

   hazard_stage_rec #(.DEC_TNEW(1'b1)) uStageM (
      .clk      (clk),
      .rst_n    (rst_n),
      .bubble_i (1'b0),
      .rec_i    (eRec),
      .rec_o    (mRec)
   );

   hazard_stage_rec #(.DEC_TNEW(1'b0)) uStageW (
      .clk      (clk),
      .rst_n    (rst_n),
      .bubble_i (1'b0),
      .rec_i    (wIn),
      .rec_o    (wRec)
   );

   // Stall when a D source is needed before an E or M producer can deliver it; W never stalls.
   always_comb begin
      stall = tuseWait(eRec, D_rs, D_rsTuse) || tuseWait(mRec, D_rs, D_rsTuse) ||
              tuseWait(eRec, D_rt, D_rtTuse) || tuseWait(mRec, D_rt, D_rtTuse);
   end

   // Forwarding selects are produced every cycle; consumers ignore them for bubbles.
   always_comb begin
      D_rsSel = dFwdSel(eRec, mRec, D_rs);
      D_rtSel = dFwdSel(eRec, mRec, D_rt);
      E_rsSel = eFwdSel(mRec, wRec, eRec.rs);
      E_rtSel = eFwdSel(mRec, wRec, eRec.rt);
      M_rtSel = recMatch(wRec, mRec.rt);
   end

   // Fields the controller never reads once a record has moved past its last consumer.
   assign unusedFields = ^{mRec.rs, wRec.rs, wRec.rt, wRec.tnew};

   // Stall-cycle counter saturates at all-ones so a long run never wraps to a small value.
   always_comb begin
      stallCnt_d = stallCnt_q;
      if (stall && !(&stallCnt_q)) begin
         stallCnt_d = stallCnt_q + 1'b1;
      end
   end

   // Register the counter; reset clears it together with the stage records.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stallCnt_q <= '0;
      end else begin
         stallCnt_q <= stallCnt_d;
      end
   end

   assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios followed by random
// instruction streams, all compared every cycle against an instruction-level
// model of the in-flight E/M/W contents.
module tb_hazard_ctrl;

   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [4:0]       D_rs;
   logic [4:0]       D_rt;
   logic [1:0]       D_rsTuse;
   logic [1:0]       D_rtTuse;
   logic [4:0]       D_writeReg;
   logic             D_regWrite;
   logic [1:0]       D_tnew;
   logic             stall;
   logic [1:0]       D_rsSel;
   logic [1:0]       D_rtSel;
   logic [1:0]       E_rsSel;
   logic [1:0]       E_rtSel;
   logic             M_rtSel;
   logic [CNT_W-1:0] stall_cnt;

   int testsRun  = 0;
   int failCount = 0;

   typedef struct {
      int rs;
      int rt;
      int wr;
      bit we;
      int tnew;
   } instr_t;

   instr_t mE, mM, mW, curD;
   int     curRsTuse, curRtTuse;
   int     mCnt;
   bit     expStall;

   hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .D_rs       (D_rs),
      .D_rt       (D_rt),
      .D_rsTuse   (D_rsTuse),
      .D_rtTuse   (D_rtTuse),
      .D_writeReg (D_writeReg),
      .D_regWrite (D_regWrite),
      .D_tnew     (D_tnew),
      .stall      (stall),
      .D_rsSel    (D_rsSel),
      .D_rtSel    (D_rtSel),
      .E_rsSel    (E_rsSel),
      .E_rtSel    (E_rtSel),
      .M_rtSel    (M_rtSel),
      .stall_cnt  (stall_cnt)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // An in-flight instruction supplies register s when it writes s and s is not $0.
   function automatic bit supplies(instr_t p, int s);
      return p.we && (p.wr != 0) && (p.wr == s);
   endfunction

   // A read must wait if any E/M producer of it is still further from done than the reader's need.
   function automatic bit mustWait(int s, int tuse);
      if (tuse == 3) return 1'b0;
      return (supplies(mE, s) && tuse < mE.tnew) || (supplies(mM, s) && tuse < mM.tnew);
   endfunction

   function automatic int dSelRef(int s);
      if (supplies(mE, s) && mE.tnew == 0) return 2;
      if (supplies(mM, s) && mM.tnew == 0) return 1;
      return 0;
   endfunction

   function automatic int eSelRef(int s);
      if (supplies(mM, s) && mM.tnew == 0) return 1;
      if (supplies(mW, s)) return 2;
      return 0;
   endfunction

   task automatic modelReset();
      mE   = '{default: 0};
      mM   = '{default: 0};
      mW   = '{default: 0};
      mCnt = 0;
   endtask

   task automatic checkVal(string tag, logic [31:0] obs, logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         failCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
         $error("[TB] check %s did not hold", tag);
      end
   endtask

   // Compare every output against the model for the instruction currently presented in D.
   task automatic checkOutput(string ph);
      expStall = mustWait(curD.rs, curRsTuse) || mustWait(curD.rt, curRtTuse);
      checkVal({ph, "_stall"},     stall,     expStall);
      checkVal({ph, "_D_rsSel"},   D_rsSel,   dSelRef(curD.rs));
      checkVal({ph, "_D_rtSel"},   D_rtSel,   dSelRef(curD.rt));
      checkVal({ph, "_E_rsSel"},   E_rsSel,   eSelRef(mE.rs));
      checkVal({ph, "_E_rtSel"},   E_rtSel,   eSelRef(mE.rt));
      checkVal({ph, "_M_rtSel"},   M_rtSel,   supplies(mW, mM.rt));
      checkVal({ph, "_stall_cnt"}, stall_cnt, mCnt);
   endtask

   // Present an instruction in D (called just after a falling edge) and check the outputs.
   task automatic applyStimulus(string ph, int rs, int rt, int rsT, int rtT, int wr, int we, int tn);
      D_rs       = 5'(rs);
      D_rt       = 5'(rt);
      D_rsTuse   = 2'(rsT);
      D_rtTuse   = 2'(rtT);
      D_writeReg = 5'(wr);
      D_regWrite = 1'(we);
      D_tnew     = 2'(tn);
      curD.rs    = rs;
      curD.rt    = rt;
      curD.wr    = wr;
      curD.we    = (we != 0);
      curD.tnew  = (tn == 3) ? 2 : tn;
      curRsTuse  = rsT;
      curRtTuse  = rtT;
      #1;
      checkOutput(ph);
   endtask

   // Clock one cycle and move every modelled instruction one stage down the pipe.
   task automatic tick();
      instr_t nextE;
      @(posedge clk);
      if (expStall && mCnt < CNT_MAX) mCnt++;
      nextE = expStall ? '{default: 0} : curD;
      mW      = mM;
      mW.tnew = 0;
      mM      = mE;
      mM.tnew = (mE.tnew > 0) ? mE.tnew - 1 : 0;
      mE      = nextE;
      @(negedge clk);
   endtask

   task automatic nop(int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus("nop", 0, 0, 3, 3, 0, 0, 0);
         tick();
      end
   endtask

   initial begin
      int rs, rt, rsT, rtT, wr, we, tn;
      rst_n      = 1'b0;
      D_rs       = '0;
      D_rt       = '0;
      D_rsTuse   = 2'd3;
      D_rtTuse   = 2'd3;
      D_writeReg = '0;
      D_regWrite = 1'b0;
      D_tnew     = '0;
      curD       = '{default: 0};
      curRsTuse  = 3;
      curRtTuse  = 3;
      modelReset();

      @(negedge clk);
      #1;
      checkOutput("reset");
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus("lwuse_lw", 29, 0, 1, 3, 1, 1, 2);
      tick();
      applyStimulus("lwuse_add", 1, 2, 1, 1, 3, 1, 1);
      checkVal("lwuse_stall_hi", stall, 1);
      tick();
      applyStimulus("lwuse_add2", 1, 2, 1, 1, 3, 1, 1);
      checkVal("lwuse_stall_lo", stall, 0);
      tick();
      applyStimulus("lwuse_nop", 0, 0, 3, 3, 0, 0, 0);
      checkVal("lwuse_E_rsSel", E_rsSel, 2);
      checkVal("lwuse_cnt", stall_cnt, 1);
      tick();
      nop(3);

      applyStimulus("beq_addu", 4, 5, 1, 1, 2, 1, 1);
      tick();
      applyStimulus("beq_beq", 2, 0, 0, 0, 0, 0, 0);
      checkVal("beq_stall_hi", stall, 1);
      tick();
      applyStimulus("beq_beq2", 2, 0, 0, 0, 0, 0, 0);
      checkVal("beq_stall_lo", stall, 0);
      checkVal("beq_D_rsSel", D_rsSel, 1);
      tick();
      nop(3);

      applyStimulus("jal_jal", 0, 0, 3, 3, 31, 1, 0);
      tick();
      applyStimulus("jal_jr", 31, 0, 0, 3, 0, 0, 0);
      checkVal("jal_stall", stall, 0);
      checkVal("jal_D_rsSel", D_rsSel, 2);
      tick();
      nop(3);

      applyStimulus("zero_addu", 4, 5, 1, 1, 0, 1, 1);
      tick();
      applyStimulus("zero_add", 0, 0, 0, 0, 3, 1, 1);
      checkVal("zero_stall", stall, 0);
      checkVal("zero_D_rsSel", D_rsSel, 0);
      checkVal("zero_D_rtSel", D_rtSel, 0);
      tick();
      applyStimulus("zero_nop", 0, 0, 3, 3, 0, 0, 0);
      checkVal("zero_E_rsSel", E_rsSel, 0);
      checkVal("zero_E_rtSel", E_rtSel, 0);
      tick();
      nop(3);

      applyStimulus("sw_lw", 29, 0, 1, 3, 5, 1, 2);
      tick();
      applyStimulus("sw_sw", 29, 5, 1, 2, 0, 0, 0);
      checkVal("sw_stall", stall, 0);
      tick();
      nop(1);
      applyStimulus("sw_inM", 0, 0, 3, 3, 0, 0, 0);
      checkVal("sw_M_rtSel", M_rtSel, 1);
      tick();
      nop(3);

      applyStimulus("rst_lw", 29, 0, 1, 3, 1, 1, 3);
      tick();
      applyStimulus("rst_add", 1, 0, 1, 3, 3, 1, 1);
      checkVal("rst_stall_before", stall, 1);
      rst_n = 1'b0;
      #1;
      checkVal("rst_stall_now", stall, 0);
      checkVal("rst_D_rsSel", D_rsSel, 0);
      checkVal("rst_E_rsSel", E_rsSel, 0);
      checkVal("rst_M_rtSel", M_rtSel, 0);
      checkVal("rst_cnt", stall_cnt, 0);
      modelReset();
      checkOutput("rst_model");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus("rst_restart", 1, 0, 1, 3, 3, 1, 1);
      checkVal("rst_restart_stall", stall, 0);
      tick();
      nop(3);

      for (int i = 0; i < 18; i++) begin
         applyStimulus("sat_lw", 29, 0, 1, 3, 7, 1, 2);
         tick();
         applyStimulus("sat_use", 7, 0, 1, 3, 8, 1, 1);
         tick();
         applyStimulus("sat_use2", 7, 0, 1, 3, 8, 1, 1);
         tick();
      end
      checkVal("sat_cnt", stall_cnt, CNT_MAX);
      nop(3);

      for (int i = 0; i < 400; i++) begin
         if (!expStall) begin
            rs  = $urandom_range(0, 7);
            rt  = $urandom_range(0, 7);
            rsT = $urandom_range(0, 3);
            rtT = $urandom_range(0, 3);
            wr  = $urandom_range(0, 7);
            we  = $urandom_range(0, 1);
            tn  = $urandom_range(0, 3);
         end
         applyStimulus("rand", rs, rt, rsT, rtT, wr, we, tn);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Producer-side control for the 5-stage MIPS pipeline (F/D/E/M/W).
- Tracks the destination register and remaining result latency (Tnew) of every in-flight instruction in E, M and W.
- Drives the D-stage stall and the select inputs of the forwarding multiplexers in D, E and M.
- Counts stall cycles for performance debug.

Parameters:
- CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- D_rs  in  5  rs field of the instruction in D.
- D_rt  in  5  rt field of the instruction in D.
- D_rsTuse  in  2  cycles after D until rs is needed; 3 = rs not read.
- D_rtTuse  in  2  cycles after D until rt is needed; 3 = rt not read.
- D_writeReg  in  5  destination register of the instruction in D.
- D_regWrite  in  1  instruction in D writes the GRF.
- D_tnew  in  2  Tnew on entering E: 0 = jal/PC+8, 1 = ALU, 2 = load.
- stall  out  1  freeze PC and F/D register; insert bubble into E.
- D_rsSel  out  2  D rs forward: 0 = GRF, 1 = M result, 2 = E result.
- D_rtSel  out  2  D rt forward, same encoding as D_rsSel.
- E_rsSel  out  2  E rs forward: 0 = pipeline reg, 1 = M ALU result, 2 = W write data.
- E_rtSel  out  2  E rt forward, same encoding as E_rsSel.
- M_rtSel  out  1  M store data forward: 0 = pipeline reg, 1 = W write data.
- stall_cnt  out  CNT_W  number of cycles in which stall was high.

Behaviour:
- State: three stage records E, M, W, each holding {rs, rt, writeReg, regWrite, tnew}.
- Reset (rst_n low, asynchronous): all records cleared to zero (regWrite = 0) and stall_cnt = 0.
  - During and immediately after reset: stall = 0 and all select outputs = 0.
  - Reset asserted mid-stall clears the records the same instant; stall drops combinationally.
- Match rule: stage X matches source s when all of the following hold:
  - X.regWrite = 1
  - X.writeReg != 0
  - X.writeReg = s
  - Register $0 never matches.
- Stall (combinational, same cycle):
  - Asserted when a D source with Tuse != 3 matches E and Tuse < E.tnew, or matches M and Tuse < M.tnew.
  - W never causes a stall.
- Record advance on each rising edge:
  - M <= E with tnew = sat_dec(E.tnew), where sat_dec(0) = 0.
  - W <= M with tnew = 0.
  - When stall = 0: E <= D inputs.
  - When stall = 1: E <= bubble (all fields 0). M and W still advance, so a stall lasts exactly until the producer's Tnew <= Tuse.
- D forward (combinational):
  - Select 2 if E matches with E.tnew = 0; else 1 if M matches with M.tnew = 0; else 0.
  - E has priority over M.
  - The W-stage result reaches D through the GRF's internal write-through; it is not forwarded here.
- E forward:
  - Select 1 if M matches E.rs/E.rt with M.tnew = 0; else 2 if W matches; else 0.
  - M has priority over W.
- M forward: M_rtSel = 1 if W matches M.rt; else 0.
- Forward selects are computed regardless of stall. Consumers ignore them for bubbles.
- stall_cnt: increments by 1 on each rising edge where stall = 1; saturates at all-ones and never wraps.
- Tnew: 2-bit unsigned throughout. D_tnew = 3 is illegal and is treated as 2.

Decomposition:
- Shared package (common pipeline constants file):
  - Tuse/Tnew widths and the TUSE_NONE = 3 constant.
  - Forward select encodings: FWD_GRF, FWD_M, FWD_E, FWD_W.
- One natural sub-module: hazard_stage_rec, a single register stage holding {rs, rt, writeReg, regWrite, tnew} with async active-low clear, a bubble input and a saturating tnew decrement. It is instantiated three times.

Test Plan:
- lw $1 (D_tnew = 2) followed by add rs = $1, Tuse = 1:
  - stall = 1 for exactly 1 cycle; stall_cnt = 1.
  - When add reaches E, E_rsSel = 2.
- addu $2 (tnew 1) followed by beq rs = $2, Tuse = 0:
  - stall = 1 for 1 cycle.
  - Next cycle, with the producer in M and tnew = 0: D_rsSel = 1, stall = 0.
- jal (writeReg $31, tnew 0) followed by jr $31, Tuse = 0: no stall; D_rsSel = 2.
- addu $0 followed by add rs = $0, Tuse = 0: stall = 0 and all selects = 0.
- lw $5, then sw with rt = $5 (Tuse 2): no stall; when sw is in M, M_rtSel = 1.
- Drop rst_n during a lw-use stall: stall, all selects and stall_cnt go to 0 immediately; after release the pipeline restarts clean with no stale matches.
